// File: rtl/id_stage.sv
// id_stage: combinational RV32I decode, branch resolution and target address.
// Optional `ID_ILLEGAL_INST_EN adds the illegal / illegal_seen outputs.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [31:0] qa,
    input  logic        is_lt,
    input  logic        is_ltu,
    input  logic        is_zero,
    output logic        brh,
    output logic [31:0] brh_addr,
    output logic        alu_src_1,
    output logic        alu_src_2,
    output logic [31:0] alu_imm_1,
    output logic [31:0] alu_imm_2,
    output logic [7:0]  alu_op,
    output logic [9:0]  mem_op,
`ifdef ID_ILLEGAL_INST_EN
    output logic        reg_we,
    output logic        illegal,
    output logic        illegal_seen
`else
    output logic        reg_we
`endif
);

    logic [4:0]  opc;
    logic [2:0]  f3;
    logic        c_load, c_opimm, c_auipc, c_store, c_op;
    logic        c_lui, c_br, c_jalr, c_jal, c_mem;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] sum;
    logic [7:0]  op_dec;
    logic        m_sign, m_ok;
    logic [2:0]  m_sz;
    logic [3:0]  m_be;
    logic [9:0]  mem_dec;
    logic        cond;

    assign opc     = inst[6:2];
    assign f3      = inst[14:12];
    assign c_load  = (opc == 5'd0);
    assign c_opimm = (opc == 5'd4);
    assign c_auipc = (opc == 5'd5);
    assign c_store = (opc == 5'd8);
    assign c_op    = (opc == 5'd12);
    assign c_lui   = (opc == 5'd13);
    assign c_br    = (opc == 5'd24);
    assign c_jalr  = (opc == 5'd25);
    assign c_jal   = (opc == 5'd27);
    assign c_mem   = c_load | c_store;

    always_comb begin
        imm = 32'h0;
        unique case (1'b1)
            c_lui, c_auipc:
                imm = {inst[31:12], 12'h000};
            c_jal:
                imm = {{12{inst[31]}}, inst[19:12], inst[20],
                       inst[30:21], 1'b0};
            c_jalr, c_load, c_opimm:
                imm = {{20{inst[31]}}, inst[31:20]};
            c_br:
                imm = {{20{inst[31]}}, inst[7], inst[30:25],
                       inst[11:8], 1'b0};
            c_store:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            default:
                imm = 32'h0;
        endcase
    end

    assign alu_src_1 = c_mem | c_opimm | c_op | c_br;
    assign alu_src_2 = c_op | c_br;
    assign alu_imm_1 = (c_auipc | c_jal | c_jalr) ? pc : 32'h0;
    assign alu_imm_2 = (c_jal | c_jalr) ? 32'd4 : imm;
    assign reg_we    = c_lui | c_auipc | c_jal | c_jalr
                     | c_load | c_opimm | c_op;

    always_comb begin
        op_dec = 8'h00;
        if (c_lui | c_auipc | c_jal | c_jalr | c_mem) begin
            op_dec = 8'h03;
        end else if (c_br) begin
            op_dec = 8'h02;
        end else if (c_op | c_opimm) begin
            unique case (f3)
                3'b000: op_dec = (c_op & inst[30]) ? 8'h02 : 8'h03;
                3'b001: op_dec = 8'h20;
                3'b010: op_dec = 8'h80;
                3'b011: op_dec = 8'h40;
                3'b100: op_dec = 8'h04;
                3'b101: op_dec = inst[30] ? 8'h08 : 8'h10;
                3'b110: op_dec = 8'h05;
                3'b111: op_dec = 8'h06;
                default: op_dec = 8'h00;
            endcase
        end
    end

    // Stores have no unsigned variants, so only loads accept 100/101.
    always_comb begin
        m_sign = 1'b0;
        m_sz   = 3'b000;
        m_be   = 4'h0;
        unique case (f3)
            3'b000: begin m_sign = c_load; m_sz = 3'b100; m_be = 4'b0001; end
            3'b001: begin m_sign = c_load; m_sz = 3'b010; m_be = 4'b0011; end
            3'b010: begin m_sz = 3'b001; m_be = 4'b1111; end
            3'b100: begin m_sz = {c_load, 2'b00}; m_be = {3'b000, c_load}; end
            3'b101: begin m_sz = {1'b0, c_load, 1'b0}; m_be = {2'b00, {2{c_load}}}; end
            default: ;
        endcase
    end

    assign m_ok    = c_mem & (m_sz != 3'b000);
    assign mem_dec = m_ok ? {m_sign, m_sz, c_store, c_load, m_be} : 10'h0;

    assign alu_op = rst ? 8'h00 : op_dec;
    assign mem_op = rst ? 10'h000 : mem_dec;

    always_comb begin
        cond = 1'b0;
        unique case (f3)
            3'b000: cond = is_zero;
            3'b001: cond = ~is_zero;
            3'b100: cond = is_lt;
            3'b101: cond = ~is_lt;
            3'b110: cond = is_ltu;
            3'b111: cond = ~is_ltu;
            default: cond = 1'b0;
        endcase
    end

    assign brh      = c_jal | c_jalr | (c_br & cond);
    assign base     = c_jalr ? qa : pc;
    assign sum      = base + imm;
    assign brh_addr = {sum[31:1], 1'b0};

`ifdef ID_ILLEGAL_INST_EN
    logic known;
    logic seen_q, seen_d;

    assign known = c_load | c_opimm | c_auipc | c_store | c_op
                 | c_lui | c_br | c_jalr | c_jal;

    assign illegal = (inst[1:0] != 2'b11) | ~known
                   | (c_mem & ~m_ok)
                   | (c_br & (f3[2:1] == 2'b01));

    assign seen_d = seen_q | illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end

    assign illegal_seen = seen_q;
`else
    logic [2:0] unused_in;
    assign unused_in = {clk, inst[1:0]};
`endif

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed test-plan vectors plus randomized
// instructions checked against a behavioural decode model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, inst, qa, qb;
    logic        is_lt, is_ltu, is_zero;
    logic        brh;
    logic [31:0] brh_addr;
    logic        alu_src_1, alu_src_2;
    logic [31:0] alu_imm_1, alu_imm_2;
    logic [7:0]  alu_op;
    logic [9:0]  mem_op;
    logic        reg_we;
`ifdef ID_ILLEGAL_INST_EN
    logic        illegal, illegal_seen;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .inst      (inst),
        .qa        (qa),
        .is_lt     (is_lt),
        .is_ltu    (is_ltu),
        .is_zero   (is_zero),
        .brh       (brh),
        .brh_addr  (brh_addr),
        .alu_src_1 (alu_src_1),
        .alu_src_2 (alu_src_2),
        .alu_imm_1 (alu_imm_1),
        .alu_imm_2 (alu_imm_2),
        .alu_op    (alu_op),
        .mem_op    (mem_op),
`ifdef ID_ILLEGAL_INST_EN
        .reg_we       (reg_we),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
`else
        .reg_we    (reg_we)
`endif
    );

    typedef struct {
        logic        brh;
        logic [31:0] addr;
        logic        s1, s2;
        logic [31:0] i1, i2;
        logic [7:0]  op;
        logic [9:0]  mem;
        logic        we;
        logic        ill;
    } exp_t;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference decode derived from the ISA field rules with plain arithmetic.
    function automatic exp_t model(logic [31:0] p, logic [31:0] i,
                                   logic [31:0] a, logic [31:0] b,
                                   logic r);
        exp_t e;
        int opc, f3, nbytes;
        bit ld, oi, au, st, op, lu, br, jr, jl, known, mvalid, cnd;
        logic signed [31:0] s;
        logic [31:0] ii, imm;
        logic [7:0] tab [8];
        tab = '{8'h03, 8'h20, 8'h80, 8'h40, 8'h04, 8'h10, 8'h05, 8'h06};
        opc = int'(i[6:2]);
        f3  = int'(i[14:12]);
        ld = opc == 0;  oi = opc == 4;  au = opc == 5;
        st = opc == 8;  op = opc == 12; lu = opc == 13;
        br = opc == 24; jr = opc == 25; jl = opc == 27;
        known = ld | oi | au | st | op | lu | br | jr | jl;
        s  = i;
        ii = s >>> 20;
        if (lu || au)
            imm = i & 32'hFFFF_F000;
        else if (jl)
            imm = (i[31] ? 32'hFFF0_0000 : 32'h0) + i[19:12] * 4096
                + i[20] * 2048 + i[30:21] * 2;
        else if (jr || ld || oi)
            imm = ii;
        else if (br)
            imm = (i[31] ? 32'hFFFF_F000 : 32'h0) + i[7] * 2048
                + i[30:25] * 32 + i[11:8] * 2;
        else if (st)
            imm = (ii & ~32'h1F) | i[11:7];
        else
            imm = 32'h0;

        e.s1 = ld | st | oi | op | br;
        e.s2 = op | br;
        e.i1 = (au | jl | jr) ? p : 32'h0;
        e.i2 = (jl | jr) ? 32'd4 : imm;
        e.we = lu | au | jl | jr | ld | oi | op;

        if (lu | au | jl | jr | ld | st) e.op = 8'h03;
        else if (br) e.op = 8'h02;
        else if (op | oi) begin
            e.op = tab[f3];
            if (f3 == 0 && op && i[30]) e.op = 8'h02;
            if (f3 == 5 && i[30]) e.op = 8'h08;
        end else e.op = 8'h00;

        nbytes = 1 << (f3 % 4);
        mvalid = ld ? (f3 inside {0, 1, 2, 4, 5}) : (st && f3 < 3);
        e.mem = 10'h0;
        if (mvalid) begin
            e.mem[9]   = ld && f3 < 2;
            e.mem[8]   = nbytes == 1;
            e.mem[7]   = nbytes == 2;
            e.mem[6]   = nbytes == 4;
            e.mem[5]   = st;
            e.mem[4]   = ld;
            e.mem[3:0] = 4'((1 << nbytes) - 1);
        end
        if (r) begin
            e.op  = 8'h00;
            e.mem = 10'h0;
        end

        case (f3)
            0: cnd = a == b;
            1: cnd = a != b;
            4: cnd = $signed(a) < $signed(b);
            5: cnd = $signed(a) >= $signed(b);
            6: cnd = a < b;
            7: cnd = a >= b;
            default: cnd = 0;
        endcase
        e.brh  = jl | jr | (br & cnd);
        e.addr = ((jr ? a : p) + imm) & ~32'h1;
        e.ill  = (i[1:0] != 2'b11) | !known | ((ld | st) & !mvalid)
               | (br & (f3 == 2 || f3 == 3));
        return e;
    endfunction

    task automatic apply(logic [31:0] p, logic [31:0] i,
                         logic [31:0] a, logic [31:0] b, logic r);
        pc      = p;
        inst    = i;
        qa      = a;
        qb      = b;
        is_zero = (a == b);
        is_lt   = ($signed(a) < $signed(b));
        is_ltu  = (a < b);
        rst     = r;
        #1;
    endtask

    task automatic check_all(string tag);
        exp_t e;
        e = model(pc, inst, qa, qb, rst);
        chk({tag, ".brh"},  brh,       e.brh);
        chk({tag, ".addr"}, brh_addr,  e.addr);
        chk({tag, ".src1"}, alu_src_1, e.s1);
        chk({tag, ".src2"}, alu_src_2, e.s2);
        chk({tag, ".imm1"}, alu_imm_1, e.i1);
        chk({tag, ".imm2"}, alu_imm_2, e.i2);
        chk({tag, ".op"},   alu_op,    e.op);
        chk({tag, ".mem"},  mem_op,    e.mem);
        chk({tag, ".we"},   reg_we,    e.we);
`ifdef ID_ILLEGAL_INST_EN
        chk({tag, ".ill"},  illegal,   e.ill);
`endif
    endtask

    localparam logic [4:0] OPCS [9] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd12,
                                        5'd13, 5'd24, 5'd25, 5'd27};

    initial begin
        logic [31:0] ri, ra, rb, rp;
        apply(32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b1);
        chk("rst.op", alu_op, 8'h00);
        chk("rst.mem", mem_op, 10'h0);
`ifdef ID_ILLEGAL_INST_EN
        chk("rst.seen", illegal_seen, 1'b0);
`endif
        @(negedge clk);

        apply(32'h0, 32'h0020_81B3, 32'h5, 32'h7, 1'b0);
        chk("add.op", alu_op, 8'h03);
        chk("add.s1", alu_src_1, 1'b1);
        chk("add.s2", alu_src_2, 1'b1);
        chk("add.we", reg_we, 1'b1);
        chk("add.mem", mem_op, 10'h0);
        chk("add.brh", brh, 1'b0);
        apply(32'h0, 32'h4020_81B3, 32'h5, 32'h7, 1'b0);
        chk("sub.op", alu_op, 8'h02);

        apply(32'h100, 32'h0020_8463, 32'h9, 32'h9, 1'b0);
        chk("beq_t.brh", brh, 1'b1);
        chk("beq_t.addr", brh_addr, 32'h108);
        chk("beq_t.op", alu_op, 8'h02);
        chk("beq_t.we", reg_we, 1'b0);
        apply(32'h100, 32'h0020_8463, 32'h9, 32'h8, 1'b0);
        chk("beq_n.brh", brh, 1'b0);

        apply(32'h40, 32'h0051_00E7, 32'h1000, 32'h0, 1'b0);
        chk("jalr.brh", brh, 1'b1);
        chk("jalr.addr", brh_addr, 32'h1004);
        chk("jalr.imm1", alu_imm_1, 32'h40);
        chk("jalr.imm2", alu_imm_2, 32'h4);
        chk("jalr.we", reg_we, 1'b1);

        apply(32'h0, 32'hFFC0_9283, 32'h0, 32'h0, 1'b0);
        chk("lh.mem", mem_op, 10'h293);
        chk("lh.imm2", alu_imm_2, 32'hFFFF_FFFC);
        chk("lh.s1", alu_src_1, 1'b1);
        chk("lh.s2", alu_src_2, 1'b0);
        chk("lh.op", alu_op, 8'h03);
        chk("lh.we", reg_we, 1'b1);

        @(negedge clk);
        apply(32'h0, 32'h0020_81B3, 32'h0, 32'h0, 1'b1);
        chk("rstadd.op", alu_op, 8'h00);
        chk("rstadd.mem", mem_op, 10'h0);
        chk("rstadd.we", reg_we, 1'b1);
        rst = 1'b0;
        #1;
        chk("rel.op", alu_op, 8'h03);

`ifdef ID_ILLEGAL_INST_EN
        @(negedge clk);
        apply(32'h0, 32'h0020_81B3, 32'h0, 32'h0, 1'b0);
        chk("legal.ill", illegal, 1'b0);
        @(posedge clk);
        #1;
        chk("legal.seen", illegal_seen, 1'b0);
        @(negedge clk);
        apply(32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
        chk("ffff.ill", illegal, 1'b1);
        chk("ffff.seen0", illegal_seen, 1'b0);
        @(posedge clk);
        #1;
        chk("ffff.seen1", illegal_seen, 1'b1);
        apply(32'h0, 32'h0020_81B3, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("hold.seen", illegal_seen, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.seen", illegal_seen, 1'b0);
        rst = 1'b0;
`endif

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            ri = $urandom;
            if ($urandom_range(0, 7) != 0)
                ri[6:2] = OPCS[$urandom_range(0, 8)];
            if ($urandom_range(0, 15) != 0)
                ri[1:0] = 2'b11;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra ^ 32'h8000_0000;
            rp = $urandom & ~32'h3;
            apply(rp, ri, ra, rb, ($urandom_range(0, 15) == 0));
            check_all("rnd");
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
